// File: rtl/lo_dec_pkg.sv
// Shared definitions for the LO quadrature decoder: quadrant codes, FSM states,
// and the {sin,cos}-to-quadrant and step-classification helpers.
package lo_dec_pkg;

   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MEAS   = 2'd1,
      ST_TRACK  = 2'd2,
      ST_LOCKED = 2'd3
   } lo_state_e;

   typedef enum logic [1:0] {
      STEP_HOLD    = 2'd0,
      STEP_FWD     = 2'd1,
      STEP_REV     = 2'd2,
      STEP_ILLEGAL = 2'd3
   } lo_step_e;

   function automatic logic [1:0] sc_to_quad(input logic [1:0] sc);
      logic [1:0] q;
      case (sc)
         2'b11:   q = Q0;
         2'b10:   q = Q1;
         2'b00:   q = Q2;
         2'b01:   q = Q3;
         default: q = Q2;
      endcase
      return q;
   endfunction

   // Quadrant arithmetic is mod 4, so 2-bit wrap gives the Q3<->Q0 neighbours.
   function automatic lo_step_e classify_step(input logic [1:0] q_old, input logic [1:0] q_new);
      lo_step_e s;
      if (q_new == q_old) begin
         s = STEP_HOLD;
      end else if (q_new == q_old + 2'd1) begin
         s = STEP_FWD;
      end else if (q_new == q_old - 2'd1) begin
         s = STEP_REV;
      end else begin
         s = STEP_ILLEGAL;
      end
      return s;
   endfunction

endpackage

// File: rtl/lo_dec_if.sv
// LO input pair and decoder status bundle; master = decoder, slave = LO source/consumer.
interface lo_dec_if #(parameter int CNT_W = 16);
   logic             sin_in;
   logic             cos_in;
   logic [1:0]       quadrant;
   logic             dir;
   logic [CNT_W-1:0] period;
   logic             period_valid;
   logic             locked;
   logic             err;
   logic [7:0]       err_cnt;

   modport master (
      input  sin_in, cos_in,
      output quadrant, dir, period, period_valid, locked, err, err_cnt
   );

   modport slave (
      output sin_in, cos_in,
      input  quadrant, dir, period, period_valid, locked, err, err_cnt
   );
endinterface

// File: rtl/lo_dec_sync.sv
// Two-flop synchronizer for the LO pair; LO_DEC_GLITCH_FILTER_EN adds a
// two-equal-sample acceptance filter (one extra cycle of latency).
module lo_dec_sync (
   input  logic       clk,
   input  logic       rstb,
   input  logic       sin_in,
   input  logic       cos_in,
   output logic [1:0] sc
);

   logic [1:0] meta_r;
   logic [1:0] sync_r;

   // metastability guard for both asynchronous LO inputs
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         meta_r <= 2'b00;
         sync_r <= 2'b00;
      end else begin
         meta_r <= {sin_in, cos_in};
         sync_r <= meta_r;
      end
   end

`ifdef LO_DEC_GLITCH_FILTER_EN
   logic [1:0] last_r;
   logic [1:0] filt_r;
   logic [1:0] filt_s;

   // accept a value only once it has been seen on two consecutive samples
   always_comb begin
      filt_s = filt_r;
      if (sync_r == last_r) begin
         filt_s = sync_r;
      end else begin
         filt_s = filt_r;
      end
   end

   // sample history and last accepted value
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         last_r <= 2'b00;
         filt_r <= 2'b00;
      end else begin
         last_r <= sync_r;
         filt_r <= filt_s;
      end
   end

   assign sc = filt_s;
`else
   assign sc = sync_r;
`endif

endmodule

// File: rtl/lo_quad_decoder.sv
// Quadrature LO decoder: quadrant/direction, period measurement, lock FSM, error count.
// Optional glitch filter in the synchronizer: define LO_DEC_GLITCH_FILTER_EN.
module lo_quad_decoder
   import lo_dec_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int LOCK_CYCLES = 4,
   parameter int TOL         = 2
) (
   input  logic     clk,
   input  logic     rstb,
   lo_dec_if.master bus
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W:0]   TOL_V   = (CNT_W+1)'(TOL);
   localparam logic [3:0]       LOCK_V  = 4'(LOCK_CYCLES);

   logic [1:0]       sc_s;
   logic [1:0]       q_new_s;
   lo_step_e         step_s;
   logic             crossing_s;
   logic             timeout_s;
   logic             abort_s;
   logic             err_ev_s;
   logic [CNT_W:0]   diff_s;
   logic [CNT_W:0]   absdiff_s;
   logic             consistent_s;

   logic [1:0]       quadrant_r;
   logic             dir_r;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] period_r;
   logic             pv_r;
   logic             locked_r;
   logic             err_r;
   logic [7:0]       err_cnt_r;
   lo_state_e        state_r;
   logic [3:0]       lock_cnt_r;

   lo_state_e        state_n;
   logic [3:0]       lock_cnt_n;
   logic [CNT_W-1:0] period_n;
   logic             pv_n;

   lo_dec_sync u_sync (
      .clk    (clk),
      .rstb   (rstb),
      .sin_in (bus.sin_in),
      .cos_in (bus.cos_in),
      .sc     (sc_s)
   );

   assign q_new_s      = sc_to_quad(sc_s);
   assign step_s       = classify_step(quadrant_r, q_new_s);
   assign crossing_s   = (step_s == STEP_FWD) && (q_new_s == Q0);
   assign timeout_s    = (cnt_r == CNT_MAX - CNT_ONE) && !crossing_s;
   assign abort_s      = (step_s == STEP_REV) || (step_s == STEP_ILLEGAL) || timeout_s;
   assign err_ev_s     = (step_s == STEP_ILLEGAL) || timeout_s;
   // widened by one bit so the sign survives and the magnitude never wraps
   assign diff_s       = {1'b0, cnt_r} - {1'b0, period_r};
   assign absdiff_s    = diff_s[CNT_W] ? ({1'b0, period_r} - {1'b0, cnt_r}) : diff_s;
   assign consistent_s = (absdiff_s <= TOL_V);

   // lock FSM next state; period is latched only from MEAS onwards
   always_comb begin
      state_n    = state_r;
      lock_cnt_n = lock_cnt_r;
      period_n   = period_r;
      pv_n       = 1'b0;
      if (abort_s) begin
         state_n    = ST_IDLE;
         lock_cnt_n = 4'd0;
      end else if (crossing_s) begin
         case (state_r)
            ST_IDLE: begin
               state_n = ST_MEAS;
            end
            ST_MEAS: begin
               period_n   = cnt_r;
               pv_n       = 1'b1;
               lock_cnt_n = 4'd0;
               state_n    = ST_TRACK;
            end
            ST_TRACK: begin
               period_n = cnt_r;
               pv_n     = 1'b1;
               if (consistent_s) begin
                  lock_cnt_n = lock_cnt_r + 4'd1;
                  if (lock_cnt_n == LOCK_V) begin
                     state_n = ST_LOCKED;
                  end else begin
                     state_n = ST_TRACK;
                  end
               end else begin
                  lock_cnt_n = 4'd0;
               end
            end
            ST_LOCKED: begin
               period_n = cnt_r;
               pv_n     = 1'b1;
               if (!consistent_s) begin
                  lock_cnt_n = 4'd0;
                  state_n    = ST_TRACK;
               end else begin
                  state_n = ST_LOCKED;
               end
            end
            default: begin
               state_n = ST_IDLE;
            end
         endcase
      end else begin
         state_n = state_r;
      end
   end

   // state, quadrant, direction and period registers
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_r    <= ST_IDLE;
         lock_cnt_r <= 4'd0;
         quadrant_r <= Q2;
         dir_r      <= 1'b1;
         period_r   <= '0;
         pv_r       <= 1'b0;
         locked_r   <= 1'b0;
      end else begin
         state_r    <= state_n;
         lock_cnt_r <= lock_cnt_n;
         quadrant_r <= q_new_s;
         period_r   <= period_n;
         pv_r       <= pv_n;
         locked_r   <= (state_n == ST_LOCKED);
         case (step_s)
            STEP_FWD: dir_r <= 1'b1;
            STEP_REV: dir_r <= 1'b0;
            default:  dir_r <= dir_r;
         endcase
      end
   end

   // period counter restarts at 1 on a crossing and parks at all-ones on timeout
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         cnt_r <= '0;
      end else if (crossing_s) begin
         cnt_r <= CNT_ONE;
      end else if (cnt_r != CNT_MAX) begin
         cnt_r <= cnt_r + CNT_ONE;
      end
   end

   // one err pulse per cycle even when a jump and a timeout coincide
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         err_r     <= 1'b0;
         err_cnt_r <= 8'd0;
      end else begin
         err_r <= err_ev_s;
         if (err_ev_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
         end
      end
   end

   assign bus.quadrant     = quadrant_r;
   assign bus.dir          = dir_r;
   assign bus.period       = period_r;
   assign bus.period_valid = pv_r;
   assign bus.locked       = locked_r;
   assign bus.err          = err_r;
   assign bus.err_cnt      = err_cnt_r;

endmodule

// File: tb/tb_lo_quad_decoder.sv
// Bench for lo_quad_decoder: step table for quadrant/dir/err, plus an LO-level
// model pushing expected period_valid events to a scoreboard queue.
module tb_lo_quad_decoder;

   localparam int CNT_W = 16;
   localparam int LOCK_CYCLES = 4;
   localparam int TOL = 2;
   localparam int QH = 128;
   localparam int CMAX = 65535;
`ifdef LO_DEC_GLITCH_FILTER_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 3;
`endif

   logic clk = 1'b0;
   logic rstb = 1'b0;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   lo_dec_if #(.CNT_W(CNT_W)) bus ();

   lo_quad_decoder #(.CNT_W(CNT_W), .LOCK_CYCLES(LOCK_CYCLES), .TOL(TOL)) dut (
      .clk  (clk),
      .rstb (rstb),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; int period; bit locked; } pv_exp_t;
   typedef struct { logic [1:0] sc; int q; bit dir; bit err; int ecnt; } vec_t;

   pv_exp_t sb_q[$];
   pv_exp_t mon_e;
   vec_t    tbl[10];

   // LO-level reference: last decoded quadrant, lock state (0 idle,1 meas,2 track,3 locked)
   int m_q = 2, m_state = 0, m_prev = 0, m_lcnt = 0, m_last = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int sc_quad(input logic [1:0] sc);
      case (sc)
         2'b11:   return 0;
         2'b10:   return 1;
         2'b00:   return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [1:0] quad_sc(input int q);
      case (q)
         0:       return 2'b11;
         1:       return 2'b10;
         2:       return 2'b00;
         default: return 2'b01;
      endcase
   endfunction

   task automatic push(input int per, input bit lk);
      pv_exp_t e;
      e.cyc = cyc + LAT;
      e.period = per;
      e.locked = lk;
      sb_q.push_back(e);
   endtask

   task automatic apply(input logic [1:0] sc);
      int qn, per, d;
      qn = sc_quad(sc);
      if (qn == (m_q + 1) % 4) begin
         if (m_q == 3) begin
            per = cyc - m_last;
            m_last = cyc;
            d = (per > m_prev) ? per - m_prev : m_prev - per;
            case (m_state)
               0: m_state = 1;
               1: begin push(per, 1'b0); m_lcnt = 0; m_state = 2; end
               2: begin
                  if (d <= TOL) begin
                     m_lcnt++;
                     if (m_lcnt >= LOCK_CYCLES) m_state = 3;
                  end else m_lcnt = 0;
                  push(per, m_state == 3);
               end
               default: begin
                  if (d > TOL) begin m_lcnt = 0; m_state = 2; end
                  push(per, m_state == 3);
               end
            endcase
            if (m_state > 1) m_prev = per;
         end
      end else if (qn != m_q) begin
         m_state = 0;
      end
      m_q = qn;
      {bus.sin_in, bus.cos_in} = sc;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic step_hold(input int q, input int n);
      apply(quad_sc(q));
      cycles(n);
   endtask

   task automatic run_lo(input int periods);
      for (int p = 0; p < periods * 4; p++) step_hold((m_q + 1) % 4, QH);
   endtask

   // scoreboard: every period_valid must match the next queued expectation
   always @(negedge clk) begin
      if (rstb && bus.period_valid) begin
         if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_pv: period_valid at cycle %0d with period %0d, none expected", cyc, bus.period);
         end else begin
            mon_e = sb_q.pop_front();
            chk("pv_cycle", cyc, mon_e.cyc);
            chk("pv_period", bus.period, mon_e.period);
            chk("pv_locked", bus.locked, mon_e.locked);
         end
      end
   end

   initial begin
      int prev_q, err_hits, err_at, exp_err_at;
      tbl[0] = '{2'b01, 3, 1'b1, 1'b0, 0};
      tbl[1] = '{2'b11, 0, 1'b1, 1'b0, 0};
      tbl[2] = '{2'b10, 1, 1'b1, 1'b0, 0};
      tbl[3] = '{2'b11, 0, 1'b0, 1'b0, 0};
      tbl[4] = '{2'b01, 3, 1'b0, 1'b0, 0};
      tbl[5] = '{2'b10, 1, 1'b0, 1'b1, 1};
      tbl[6] = '{2'b00, 2, 1'b1, 1'b0, 1};
      tbl[7] = '{2'b11, 0, 1'b1, 1'b1, 2};
      tbl[8] = '{2'b01, 3, 1'b0, 1'b0, 2};
      tbl[9] = '{2'b00, 2, 1'b0, 1'b0, 2};

      bus.sin_in = 1'b0;
      bus.cos_in = 1'b0;
      cycles(3);
      chk("rst_quadrant", bus.quadrant, 2);
      chk("rst_dir", bus.dir, 1);
      chk("rst_period", bus.period, 0);
      chk("rst_locked", bus.locked, 0);
      chk("rst_err_cnt", bus.err_cnt, 0);
      rstb = 1'b1;
      cycles(3);

      // decode table: latency, mapping, direction and illegal jumps
      for (int i = 0; i < 10; i++) begin
         prev_q = (i == 0) ? 2 : tbl[i-1].q;
         apply(tbl[i].sc);
         cycles(LAT - 1);
         chk($sformatf("v%0d_quad_before", i), bus.quadrant, prev_q);
         cycles(1);
         chk($sformatf("v%0d_quad", i), bus.quadrant, tbl[i].q);
         chk($sformatf("v%0d_dir", i), bus.dir, tbl[i].dir);
         chk($sformatf("v%0d_err", i), bus.err, tbl[i].err);
         chk($sformatf("v%0d_err_cnt", i), bus.err_cnt, tbl[i].ecnt);
         cycles(1);
         chk($sformatf("v%0d_err_pulse_end", i), bus.err, 0);
         cycles(4);
      end

      // ideal 512-cycle LO: locks on the 6th crossing
      run_lo(6);
      chk("ideal_locked", bus.locked, 1);
      chk("ideal_dir", bus.dir, 1);
      chk("ideal_err_cnt", bus.err_cnt, 2);

      // one 520-cycle period unlocks, then relock
      step_hold(3, QH);
      step_hold(0, QH);
      step_hold(1, QH + 8);
      step_hold(2, QH);
      run_lo(1);
      chk("stretch_unlocked", bus.locked, 0);
      run_lo(5);
      chk("stretch_relocked", bus.locked, 1);

      // illegal 11 -> 00 jump while locked
      step_hold(3, QH);
      step_hold(0, QH);
      apply(2'b00);
      cycles(LAT);
      chk("jump_err", bus.err, 1);
      chk("jump_err_cnt", bus.err_cnt, 3);
      chk("jump_locked", bus.locked, 0);
      chk("jump_quadrant", bus.quadrant, 2);
      cycles(1);
      chk("jump_err_pulse_end", bus.err, 0);
      cycles(QH - LAT - 1);
      run_lo(6);
      chk("jump_relocked", bus.locked, 1);

      // reverse rotation
      apply(quad_sc(1));
      cycles(LAT);
      chk("rev_dir", bus.dir, 0);
      chk("rev_locked", bus.locked, 0);
      cycles(QH - LAT);
      for (int k = 0; k < 7; k++) step_hold((m_q + 3) % 4, QH);
      chk("rev_still_unlocked", bus.locked, 0);
      run_lo(6);
      chk("rev_relocked", bus.locked, 1);

      // asynchronous reset while locked
      rstb = 1'b0;
      #1;
      chk("mid_rst_quadrant", bus.quadrant, 2);
      chk("mid_rst_dir", bus.dir, 1);
      chk("mid_rst_period", bus.period, 0);
      chk("mid_rst_pv", bus.period_valid, 0);
      chk("mid_rst_locked", bus.locked, 0);
      chk("mid_rst_err", bus.err, 0);
      chk("mid_rst_err_cnt", bus.err_cnt, 0);
      sb_q.delete();
      m_state = 0;
      m_q = 2;
      cycles(4);
      rstb = 1'b1;
      cycles(2);
      run_lo(5);
      chk("post_rst_not_yet_locked", bus.locked, 0);
      run_lo(1);
      chk("post_rst_relocked", bus.locked, 1);

      // frozen inputs: single timeout err after the counter saturates
      exp_err_at = m_last + LAT + CMAX - 1;
      err_hits = 0;
      err_at = -1;
      for (int i = 0; i < CMAX + 200; i++) begin
         cycles(1);
         if (bus.err) begin
            err_hits++;
            if (err_at < 0) err_at = cyc;
         end
      end
      chk("timeout_err_pulses", err_hits, 1);
      chk("timeout_err_cycle", err_at, exp_err_at);
      chk("timeout_err_cnt", bus.err_cnt, 1);
      chk("timeout_locked", bus.locked, 0);
      m_state = 0;
      run_lo(2);

      cycles(LAT + 2);
      chk("scoreboard_drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
